// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue unit: datapath ALU operation codes and
// the issue FSM state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RISC-V funct3/funct7b5 decode into the datapath ALU code.
// SLTU and SRA/SRAI have no ALU code and are flagged as unsupported.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       rtype,
  output logic [2:0] alu_sel,
  output logic       is_shift,
  output logic       unsupported
);

  always_comb begin
    alu_sel     = ALU_ADD;
    is_shift    = 1'b0;
    unsupported = 1'b0;
    case (funct3)
      3'b000: alu_sel = (rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: begin
        alu_sel  = ALU_SLL;
        is_shift = 1'b1;
      end
      3'b010: alu_sel = ALU_SLT;
      3'b011: unsupported = 1'b1;
      3'b100: alu_sel = ALU_XOR;
      3'b101: begin
        // bit 30 set selects arithmetic shift right, which the ALU lacks
        if (funct7b5) begin
          unsupported = 1'b1;
        end else begin
          alu_sel  = ALU_SRL;
          is_shift = 1'b1;
        end
      end
      3'b110: alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue unit between a request/response handshake and an external datapath
// ALU: decode and register operands, execute for one cycle, hold the response.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic              req_rtype,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        sel_q, sel_d;
  logic              unsup_q, unsup_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_err_q, rsp_err_d;

  logic [2:0] dec_sel;
  logic       dec_shift;
  logic       dec_unsup;
  logic       accept;

  alu_op_decode u_decode (
    .funct3      (req_funct3),
    .funct7b5    (req_funct7b5),
    .rtype       (req_rtype),
    .alu_sel     (dec_sel),
    .is_shift    (dec_shift),
    .unsupported (dec_unsup)
  );

  // Ready in RESP follows rsp_ready so a retiring response hands off directly
  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    unsup_d      = unsup_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_result_d = unsup_q ? '0 : alu_result;
        rsp_zero_d   = unsup_q ? 1'b0 : alu_zero;
        rsp_err_d    = unsup_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = req_valid ? ST_EXEC : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      a_d     = req_a;
      b_d     = dec_shift ? {{(DATA_W-5){1'b0}}, req_b[4:0]} : req_b;
      sel_d   = dec_sel;
      unsup_d = dec_unsup;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      unsup_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      unsup_q      <= unsup_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_in_a   = a_q;
  assign alu_in_b   = b_q;
  assign alu_sel    = sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: a stand-in datapath ALU, a transaction-level
// reference model checked every cycle, directed scenarios and random traffic.
module tb_alu_issue_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_funct7b5;
  logic        req_rtype;
  logic [31:0] req_a, req_b;
  logic [31:0] alu_in_a, alu_in_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  alu_issue_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_funct7b5 (req_funct7b5),
    .req_rtype    (req_rtype),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_in_a     (alu_in_a),
    .alu_in_b     (alu_in_b),
    .alu_sel      (alu_sel),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath ALU stand-in; shifts use the whole alu_in_b so unmasked amounts show up
  always_comb begin
    alu_result = 32'h0;
    case (alu_sel)
      3'b000: alu_result = alu_in_a + alu_in_b;
      3'b001: alu_result = alu_in_a - alu_in_b;
      3'b010: alu_result = alu_in_a & alu_in_b;
      3'b011: alu_result = alu_in_a | alu_in_b;
      3'b100: alu_result = alu_in_a ^ alu_in_b;
      3'b101: alu_result = {31'h0, $signed(alu_in_a) < $signed(alu_in_b)};
      3'b110: alu_result = alu_in_a << alu_in_b;
      default: alu_result = alu_in_a >> alu_in_b;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        err;
    logic [2:0]  sel;
    logic [31:0] ain;
    logic [31:0] bin;
  } exp_t;

  // Expected outcome of one request, straight from the RISC-V meaning of funct3
  function automatic exp_t model(logic [2:0] f3, logic f7, logic rt, logic [31:0] a, logic [31:0] b);
    exp_t e;
    e.err = 1'b0;
    e.ain = a;
    e.bin = b;
    e.res = 32'h0;
    e.sel = 3'b000;
    case (f3)
      3'b000: begin
        if (rt && f7) begin e.res = a - b; e.sel = 3'b001; end
        else begin e.res = a + b; e.sel = 3'b000; end
      end
      3'b001: begin e.res = a << b[4:0]; e.sel = 3'b110; e.bin = {27'h0, b[4:0]}; end
      3'b010: begin e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.sel = 3'b101; end
      3'b011: e.err = 1'b1;
      3'b100: begin e.res = a ^ b; e.sel = 3'b100; end
      3'b101: begin
        if (f7) e.err = 1'b1;
        else begin e.res = a >> b[4:0]; e.sel = 3'b111; e.bin = {27'h0, b[4:0]}; end
      end
      3'b110: begin e.res = a | b; e.sel = 3'b011; end
      default: begin e.res = a & b; e.sel = 3'b010; end
    endcase
    if (e.err) e.res = 32'h0;
    e.zero = !e.err && (e.res == 32'h0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: at most one operation outstanding, response two cycles after acceptance
  bit   started = 0;
  bit   have_op = 0;
  bit   rst_prev = 0;
  int   now = 0;
  int   acc_cyc = 0;
  exp_t cur;

  always @(negedge clk) begin
    bit exp_rr, exp_rv;
    now++;
    if (!started) begin
      if (rst) begin
        started  = 1;
        have_op  = 0;
        rst_prev = 1;
      end
    end else begin
      exp_rv = have_op && (now >= acc_cyc + 2);
      exp_rr = !have_op || (exp_rv && rsp_ready);
      chk("req_ready", {31'h0, req_ready}, {31'h0, exp_rr});
      chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_rv});
      if (have_op && (now >= acc_cyc + 1) && !cur.err) begin
        chk("alu_in_a", alu_in_a, cur.ain);
        chk("alu_in_b", alu_in_b, cur.bin);
        chk("alu_sel", {29'h0, alu_sel}, {29'h0, cur.sel});
      end
      if (exp_rv) begin
        chk("rsp_result", rsp_result, cur.res);
        chk("rsp_zero", {31'h0, rsp_zero}, {31'h0, cur.zero});
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, cur.err});
      end
      if (rst_prev) begin
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_flags", {29'h0, rsp_zero, rsp_err, rsp_valid}, 32'h0);
        chk("rst_alu_a", alu_in_a, 32'h0);
        chk("rst_alu_b", alu_in_b, 32'h0);
        chk("rst_alu_sel", {29'h0, alu_sel}, 32'h0);
      end
      rst_prev = rst;
      if (rst) begin
        have_op = 0;
      end else begin
        if (exp_rv && rsp_ready) have_op = 0;
        if (exp_rr && req_valid) begin
          have_op = 1;
          acc_cyc = now;
          cur     = model(req_funct3, req_funct7b5, req_rtype, req_a, req_b);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic f7, input logic rt,
                       input logic [31:0] a, input logic [31:0] b);
    req_valid    = v;
    req_funct3   = f3;
    req_funct7b5 = f7;
    req_rtype    = rt;
    req_a        = a;
    req_b        = b;
  endtask

  logic [31:0] b2b_a [4] = '{32'd1, 32'd100, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
  logic [31:0] b2b_b [4] = '{32'd2, 32'd200, 32'd1, 32'd1};
  logic [31:0] b2b_s [4] = '{32'd3, 32'd300, 32'h0, 32'h8000_0000};

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    drive(0, 3'b000, 0, 0, 32'h0, 32'h0);
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("first_req_ready", {31'h0, req_ready}, 32'd1);
    chk("first_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    step();

    // SUB 5-5
    drive(1, 3'b000, 1, 1, 32'd5, 32'd5);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("sub_sel", {29'h0, alu_sel}, 32'b001);
    step();
    @(negedge clk);
    chk("sub_valid", {31'h0, rsp_valid}, 32'd1);
    chk("sub_result", rsp_result, 32'd0);
    chk("sub_zero", {31'h0, rsp_zero}, 32'd1);
    chk("sub_err", {31'h0, rsp_err}, 32'd0);
    step();

    // SLL with an oversized shift amount
    drive(1, 3'b001, 0, 1, 32'd1, 32'h0000_0024);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("sll_alu_b", alu_in_b, 32'd4);
    step();
    @(negedge clk);
    chk("sll_result", rsp_result, 32'h10);
    step();

    // SRA is unsupported
    drive(1, 3'b101, 1, 1, 32'h8000_0000, 32'd3);
    step();
    req_valid = 1'b0;
    step();
    @(negedge clk);
    chk("sra_err", {31'h0, rsp_err}, 32'd1);
    chk("sra_result", rsp_result, 32'd0);
    chk("sra_zero", {31'h0, rsp_zero}, 32'd0);
    step();

    // Backpressure with a waiting request
    rsp_ready = 1'b0;
    drive(1, 3'b000, 0, 1, 32'd10, 32'd20);
    step();
    drive(1, 3'b000, 0, 0, 32'd7, 32'd8);
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_req_ready", {31'h0, req_ready}, 32'd0);
      chk("bp_hold_result", rsp_result, 32'd30);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'h0, req_ready}, 32'd1);
    chk("bp_release_result", rsp_result, 32'd30);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_exec_valid", {31'h0, rsp_valid}, 32'd0);
    chk("bp_exec_a", alu_in_a, 32'd7);
    step();
    @(negedge clk);
    chk("bp_second_result", rsp_result, 32'd15);
    step();

    // Four back-to-back ADDs
    drive(1, 3'b000, 0, 1, b2b_a[0], b2b_b[0]);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, 3'b000, 0, 1, b2b_a[i+1], b2b_b[i+1]);
      else req_valid = 1'b0;
      step();
      @(negedge clk);
      chk("b2b_valid", {31'h0, rsp_valid}, 32'd1);
      chk("b2b_sum", rsp_result, b2b_s[i]);
      step();
    end

    // Reset during EXEC
    drive(1, 3'b000, 0, 1, 32'd3, 32'd4);
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", {31'h0, req_ready}, 32'd1);
    chk("rstmid_valid", {31'h0, rsp_valid}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      chk("rstmid_no_rsp", {31'h0, rsp_valid}, 32'd0);
    end
    step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 5) == 0) b = a;
      drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), a, b);
      rsp_ready = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 Parameter: DATA_W, default 32, operand and result width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  unit accepts request this cycle.
REQ-006 req_funct3  in  3  RISC-V funct3 of the operation.
REQ-007 req_funct7b5  in  1  bit 30 of the instruction (SUB select).
REQ-008 req_rtype  in  1  1 = R-type, 0 = I-type.
REQ-009 req_a, req_b  in  DATA_W  operands A and B.
REQ-010 alu_in_a, alu_in_b  out  DATA_W  operands driven to the datapath ALU.
REQ-011 alu_sel  out  3  ALU operation code.
REQ-012 alu_result  in  DATA_W  ALU result.
REQ-013 alu_zero  in  1  ALU zero flag.
REQ-014 rsp_valid  out  1  response present.
REQ-015 rsp_ready  in  1  consumer accepts response.
REQ-016 rsp_result  out  DATA_W  captured result.
REQ-017 rsp_zero  out  1  captured zero flag.
REQ-018 rsp_err  out  1  unsupported operation.

Function
REQ-019 The alu_sel codes SHALL be: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111.
REQ-020 The decode SHALL map funct3 as follows: 000 → ADD, or SUB when req_rtype=1 and funct7b5=1; 111 → AND; 110 → OR; 100 → XOR; 010 → SLT; 001 → SLL; 101 → SRL when funct7b5=0.
REQ-021 funct3 011 (SLTU) and funct3 101 with funct7b5=1 (SRA) SHALL be unsupported: they are accepted, the ALU is not used, and the response is rsp_err=1, rsp_result=0, rsp_zero=0.
REQ-022 For SLL/SRL, alu_in_b SHALL be req_b[4:0] zero-extended; for all other operations, alu_in_b SHALL be req_b unmodified.
REQ-023 The FSM SHALL have three states: IDLE, EXEC and RESP.
  - IDLE: req_ready=1. On req_valid, capture operands and decoded code into registers and go to EXEC.
  - EXEC: req_ready=0. Drive alu_* from the registers. At the end of the cycle, capture alu_result/alu_zero into rsp_* and go to RESP.
  - RESP: rsp_valid=1.
    - rsp_ready=0: hold all rsp_* values stable.
    - rsp_ready=1, req_valid=0: go to IDLE.
    - rsp_ready=1, req_valid=1: req_ready=1 this cycle, the new request is captured, and the state goes to EXEC (back-to-back handoff).
REQ-024 req_ready in RESP SHALL equal rsp_ready, combinationally.
REQ-025 Latency: a request accepted in cycle N SHALL have rsp_valid=1 in cycle N+2; peak throughput is one operation per 2 cycles.
REQ-026 alu_in_a, alu_in_b and alu_sel SHALL be driven from registers only, and SHALL stay stable from EXEC until the next capture.
REQ-027 No request SHALL be dropped or duplicated, and no response SHALL be dropped or duplicated, under any req_valid/rsp_ready pattern.
REQ-028 The unit SHALL NOT recompute the zero flag; rsp_zero is the ALU's flag as captured.

Reset
REQ-029 When rst=1 at a clock edge, the state SHALL become IDLE, and rsp_valid, rsp_result, rsp_zero, rsp_err, alu_in_a, alu_in_b and alu_sel SHALL become 0.
REQ-030 Reset asserted in EXEC or RESP SHALL abandon the operation with no response issued.
REQ-031 req_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-032 The alu_sel code constants and the FSM state encoding SHALL reside in the shared package alu_pkg.
REQ-033 The funct3/funct7b5 decode SHALL be the combinational sub-module alu_op_decode, with outputs alu_sel, is_shift and unsupported.
REQ-034 The ALU itself SHALL NOT be instantiated inside the unit; it connects at the datapath level.

Verification
REQ-035 Scenario SUB: R-type funct3=000, funct7b5=1, a=5, b=5 → alu_sel=001, and at N+2 rsp_result=0, rsp_zero=1, rsp_err=0.
REQ-036 Scenario shift masking: funct3=001, a=1, b=0x00000024 → alu_in_b=4, rsp_result=0x10.
REQ-037 Scenario unsupported: funct3=101, funct7b5=1 → rsp_err=1, rsp_result=0, rsp_zero=0.
REQ-038 Scenario backpressure: rsp_ready=0 for 5 cycles with req_valid=1 → req_ready=0 throughout and rsp_* stable; the first rsp_ready=1 cycle retires the response and captures the next request.
REQ-039 Scenario back-to-back: 4 ADDs with rsp_ready=1 held → responses at N+2, N+4, N+6, N+8, in order and with correct sums.
REQ-040 Scenario reset mid-op: rst pulse during EXEC → no rsp_valid follows, and req_ready=1 in the cycle after reset.
